// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC blocks: arctangent table, gain correction and FSM states.
package cordic_pkg;

    localparam int MAX_ITER = 12;
    localparam int LUT_W    = 16;
    localparam int FRAC_IN  = 6;
    localparam int K_FRAC   = 12;

    // 1/K for 12 micro-rotations, Q1.12
    localparam logic signed [LUT_W-1:0] CORDIC_K = 16'sd2487;

    // atan(2^-i) in Q1.12
    localparam logic signed [LUT_W-1:0] ATAN_LUT [MAX_ITER] = '{
        16'sd3217, 16'sd1899, 16'sd1003, 16'sd509,
        16'sd256,  16'sd128,  16'sd64,   16'sd32,
        16'sd16,   16'sd8,    16'sd4,    16'sd2
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        SCALE  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_round_sat.sv
// Round-half-up by FRAC_SH bits, then saturate into a signed OUT_W result.
module cordic_round_sat #(
    parameter int IN_W    = 16,
    parameter int FRAC_SH = 6,
    parameter int OUT_W   = 8
) (
    input  logic signed [IN_W-1:0]  v_i,
    output logic signed [OUT_W-1:0] q_o
);

    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = ~MAX_V;
    localparam logic signed [IN_W:0] RND   = {{(IN_W+1-FRAC_SH){1'b0}}, 1'b1, {(FRAC_SH-1){1'b0}}};

    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [IN_W-1:0] v);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] sh;
        sum = {v[IN_W-1], v} + RND;
        sh  = sum >>> FRAC_SH;
        if (sh > MAX_V)
            return MAX_V[OUT_W-1:0];
        else if (sh < MIN_V)
            return MIN_V[OUT_W-1:0];
        else
            return sh[OUT_W-1:0];
    endfunction

    always_comb begin
        q_o = round_sat(v_i);
    end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC vectoring engine: (x, y) in Q1.6 -> gain-corrected magnitude and atan2 angle in Q1.6.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ITER_COUNT = 12,
    parameter int INT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] mag_out,
    output logic signed [DATA_WIDTH-1:0] angle_out,
    output logic                         range_err
);

    localparam int IT_W = $clog2(MAX_ITER);
    localparam int PW   = 2 * INT_WIDTH;

    state_t                        state_q, state_d;
    logic [IT_W-1:0]               iter_q;
    logic                          err_q, zero_q, rerr_q;
    logic signed [INT_WIDTH-1:0]   x_q, y_q, z_q;
    logic signed [DATA_WIDTH-1:0]  mag_q, ang_q;
    logic signed [DATA_WIDTH-1:0]  mag_rs, ang_rs;

    logic                          accept, last_iter;
    logic signed [INT_WIDTH-1:0]   xs, ys, lut;
    logic signed [PW-1:0]          prod, m;

    assign accept    = in_valid && (state_q == IDLE);
    assign last_iter = (iter_q == IT_W'(ITER_COUNT - 1));

    always_comb begin
        xs   = x_q >>> iter_q;
        ys   = y_q >>> iter_q;
        lut  = INT_WIDTH'(ATAN_LUT[iter_q]);
        prod = PW'(x_q) * PW'(CORDIC_K);
        m    = prod >>> K_FRAC;
    end

    cordic_round_sat #(.IN_W(PW), .FRAC_SH(FRAC_IN), .OUT_W(DATA_WIDTH)) u_rs_mag (
        .v_i (m),
        .q_o (mag_rs)
    );

    cordic_round_sat #(.IN_W(INT_WIDTH), .FRAC_SH(FRAC_IN), .OUT_W(DATA_WIDTH)) u_rs_ang (
        .v_i (z_q),
        .q_o (ang_rs)
    );

    // Datapath: sign-extended Q1.6 -> Q3.12 load, then one micro-rotation per edge
    always_ff @(posedge clk) begin
        if (accept) begin
            x_q <= {{(INT_WIDTH-DATA_WIDTH-FRAC_IN){x_in[DATA_WIDTH-1]}}, x_in, {FRAC_IN{1'b0}}};
            y_q <= {{(INT_WIDTH-DATA_WIDTH-FRAC_IN){y_in[DATA_WIDTH-1]}}, y_in, {FRAC_IN{1'b0}}};
            z_q <= '0;
        end else if (state_q == ROTATE) begin
            if (!y_q[INT_WIDTH-1]) begin
                x_q <= x_q + ys;
                y_q <= y_q - xs;
                z_q <= z_q + lut;
            end else begin
                x_q <= x_q - ys;
                y_q <= y_q + xs;
                z_q <= z_q - lut;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            rerr_q  <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                iter_q <= '0;
                err_q  <= x_in[DATA_WIDTH-1];
                zero_q <= (x_in == '0) && (y_in == '0);
            end else if (state_q == ROTATE) begin
                iter_q <= iter_q + 1'b1;
            end
            // Invalid or zero operands run the full latency; only the result is masked
            if (state_q == SCALE) begin
                mag_q  <= (err_q || zero_q) ? '0 : mag_rs;
                ang_q  <= (err_q || zero_q) ? '0 : ang_rs;
                rerr_q <= err_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ROTATE;
            ROTATE:  if (last_iter) state_d = SCALE;
            SCALE:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        mag_out   = mag_q;
        angle_out = ang_q;
        range_err = rerr_q;
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed and randomised checks of the CORDIC vectoring engine against hand values and an atan2/hypot model.
module tb_cordic_vectoring;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x_in;
    logic signed [7:0] y_in;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] mag_out;
    logic signed [7:0] angle_out;
    logic              range_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cordic_vectoring #(.DATA_WIDTH(8), .ITER_COUNT(12), .INT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out),
        .range_err (range_err)
    );

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int diff;
        total++;
        diff = obs - exp;
        if (diff > tol || diff < -tol) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Accept at E0, then count edges until out_valid shows up
    task automatic start_and_wait(input logic [7:0] xi, input logic [7:0] yi, output int lat);
        @(negedge clk);
        x_in     = xi;
        y_in     = yi;
        in_valid = 1'b1;
        chk("in_ready_before_accept", int'(in_ready), 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = 8'h55;
        y_in     = 8'hAA;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) chk("no_in_ready_with_out_valid", int'(in_ready), 0, 0);
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", int'(out_valid), 0, 0);
        chk("in_ready_after_handshake", int'(in_ready), 1, 0);
    endtask

    task automatic do_op(input string tag, input logic [7:0] xi, input logic [7:0] yi,
                         input int em, input int ea, input int ee, input int tol);
        int lat;
        start_and_wait(xi, yi, lat);
        chk({tag, "_latency"}, lat, 13, 0);
        chk({tag, "_mag"}, int'(mag_out), em, tol);
        chk({tag, "_angle"}, int'(angle_out), ea, tol);
        chk({tag, "_range_err"}, int'(range_err), ee, 0);
        release_out();
    endtask

    initial begin
        int lat;
        logic [7:0] rx, ry;
        logic signed [7:0] sy;
        real mr, ar;
        int em, ea;

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_mag", int'(mag_out), 0, 0);
        chk("rst_angle", int'(angle_out), 0, 0);
        chk("rst_range_err", int'(range_err), 0, 0);

        do_op("unit_x", 8'h40, 8'h00, 64, 0, 0, 1);
        do_op("diag_pos", 8'h20, 8'h20, 45, 50, 0, 1);
        do_op("diag_neg", 8'h20, 8'hE0, 45, -50, 0, 1);
        do_op("unit_y", 8'h00, 8'h40, 64, 101, 0, 1);
        do_op("sat", 8'h7F, 8'h7F, 127, 50, 0, 1);
        do_op("zero", 8'h00, 8'h00, 0, 0, 0, 0);
        do_op("neg_x", 8'hC0, 8'h10, 0, 0, 1, 0);

        // Consumer stalls for 5 cycles while a new operand is offered
        start_and_wait(8'h20, 8'h20, lat);
        chk("stall_latency", lat, 13, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x_in     = 8'h40;
            y_in     = 8'h00;
            @(posedge clk);
            #1;
            chk("stall_out_valid", int'(out_valid), 1, 0);
            chk("stall_in_ready", int'(in_ready), 0, 0);
            chk("stall_mag", int'(mag_out), 45, 1);
            chk("stall_angle", int'(angle_out), 50, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        do_op("after_stall", 8'h00, 8'hC0, 64, -101, 0, 1);

        // Reset during iteration 6
        @(negedge clk);
        x_in     = 8'h20;
        y_in     = 8'h20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1, 0);
        chk("midrst_out_valid", int'(out_valid), 0, 0);
        chk("midrst_mag", int'(mag_out), 0, 0);
        chk("midrst_angle", int'(angle_out), 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("midrst_no_output", int'(out_valid), 0, 0);
        end
        do_op("after_rst", 8'h20, 8'hE0, 45, -50, 0, 1);

        for (int k = 0; k < 10; k++) begin
            rx = 8'($urandom_range(0, 127));
            ry = 8'($urandom_range(0, 255));
            sy = ry;
            mr = $sqrt(real'(int'(rx)) ** 2 + real'(int'(sy)) ** 2);
            ar = (rx == 0 && sy == 0) ? 0.0 : $atan2(real'(int'(sy)), real'(int'(rx))) * 64.0;
            em = $rtoi($floor(mr + 0.5));
            if (em > 127) em = 127;
            ea = $rtoi($floor(ar + 0.5));
            do_op("rand", rx, ry, em, ea, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC vectoring-mode engine: the inverse of the rotation-mode sin/cos block. It accepts a Cartesian vector (x, y) in the right half-plane and returns the gain-corrected magnitude sqrt(x²+y²) and angle atan2(y, x) in radians. The angle output uses the same Q1.6 format the rotation block takes as input, so the two blocks chain directly. It runs one micro-rotation per clock behind a valid/ready handshake on both sides.

## Interface
- DATA_WIDTH, 8, I/O width; signed Q1.6 (1 sign, 1 integer, 6 fraction bits)
- ITER_COUNT, 12, micro-rotations per operation; max 12, bounded by the LUT depth
- INT_WIDTH, 16, internal datapath width; signed Q3.12
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  x_in/y_in valid
- in_ready  out  1  block can accept an operand; high only in IDLE
- x_in  in  DATA_WIDTH  signed Q1.6 x
- y_in  in  DATA_WIDTH  signed Q1.6 y
- out_valid  out  1  results valid; held until accepted
- out_ready  in  1  consumer accepts results
- mag_out  out  DATA_WIDTH  signed Q1.6 magnitude, saturated to 0x7F
- angle_out  out  DATA_WIDTH  signed Q1.6 radians, range ±π/2
- range_err  out  1  x_in was negative; qualified by out_valid

## Operation
- FSM states: IDLE, ROTATE, SCALE, DONE.
- IDLE → ROTATE on in_valid && in_ready. The accept edge loads:
  - x = x_in<<6, sign-extended to INT_WIDTH
  - y = y_in<<6, sign-extended to INT_WIDTH
  - z = 0, iter = 0
  - err = x_in[MSB]
  - zero = (x_in==0 && y_in==0)
- ROTATE, one edge per iter i. Let d = +1 if y ≥ 0, otherwise −1.
  - x ← x + d·(y>>>i)
  - y ← y − d·(x>>>i)
  - z ← z + d·atan_lut[i]
  - All three use values from before the edge; shifts are arithmetic.
  - After i = ITER_COUNT−1 the FSM moves to SCALE.
- SCALE, one edge:
  - m = (x · CORDIC_K) >>> 12, where CORDIC_K = 2487 (0.60718, Q1.12); the product is held at 2·INT_WIDTH bits.
  - mag_out = round_sat(m); angle_out = round_sat(z).
  - round_sat(v): add 1<<5, arithmetic shift right by 6, saturate to [0x80, 0x7F].
  - If err or zero: mag_out = 0 and angle_out = 0. range_err = err.
  - The FSM moves to DONE.
- DONE: out_valid = 1 and outputs are stable. On out_ready the FSM moves to IDLE.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accept edge and may change afterwards.
- Invalid and zero inputs consume the full latency; results are only masked.

## Timing
- Reset values: in_ready = 1 once reset is released; out_valid = 0, mag_out = 0, angle_out = 0, range_err = 0; FSM in IDLE; iter = 0.
- Latency: with the accept at edge E0, iterations occupy E1..E12 and SCALE is E13. out_valid is high from E13 until the out_ready edge.
- Throughput: one result per 15 cycles with out_ready tied high. in_ready rises the cycle after the output handshake.
- in_ready and out_valid are never high in the same cycle.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is ever presented.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package cordic_pkg holds:
  - atan_lut[0:11]: atan(2^-i) in Q1.12, the same constants as the rotation block, sign-extended to INT_WIDTH
  - CORDIC_K, MAX_ITER = 12
  - the state enum typedef
- Sub-module cordic_round_sat (parameterised input width and fraction shift) implements round-half-up and saturation. It is instantiated twice, for magnitude and for angle.

## Test plan
- Reset held, then released → in_ready = 1, out_valid = 0, all outputs 0.
- (x, y) = (0x40, 0x00), i.e. (1.0, 0) → mag_out = 0x40 and angle_out = 0x00 (each ±1 LSB), out_valid on E13.
- (0x20, 0x20) → mag_out = 0x2D, angle_out = 0x32 (π/4).
- (0x20, 0xE0) → mag_out = 0x2D, angle_out = 0xCE (−π/4). Each value ±1 LSB.
- Boundaries, one operation each:
  - (0x00, 0x40) → angle_out = 0x64/0x65, mag_out = 0x40 (±1 LSB)
  - (0x7F, 0x7F) → mag_out saturates to 0x7F, angle_out = 0x32
  - (0x00, 0x00) → mag_out = 0, angle_out = 0, range_err = 0
  - x_in = 0xC0 → range_err = 1, mag_out = 0, angle_out = 0
- Handshake and reset:
  - out_ready held low for 5 cycles → outputs stable, in_ready = 0, and new in_valid is ignored.
  - rst pulsed at iteration 6 → immediate reset values; the next operation returns correct results.
  - Random x ≥ 0 and random y, checked against an atan2/hypot model within ±1 LSB.
